// File: rtl/inst_mem_loader.sv
// rtl/inst_mem_loader.sv - byte-streamed instruction memory loader with CPU reset sequencing
module inst_mem_loader #(
    parameter int unsigned MEM_SIZE    = 32'd512,
    parameter int unsigned HOLD_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ld_start,
    input  logic [15:0] ld_len,
    input  logic        ld_valid,
    input  logic [7:0]  ld_data,
    output logic        ld_ready,
    input  logic [31:0] PC,
    output logic [31:0] Instruction,
    output logic        cpu_reset,
    output logic        load_done,
    output logic        load_err
);

    localparam int AW = (MEM_SIZE > 1) ? $clog2(MEM_SIZE) : 1;
    localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        HOLD,
        RUN
    } state_t;

    state_t          state_q, state_d;
    logic [15:0]     addr_q, addr_d;
    logic [15:0]     len_q, len_d;
    logic [HW-1:0]   hold_q, hold_d;
    logic            err_q, err_d;

    logic            len_ok;
    logic            wr_en;
    logic            last_byte;

    logic [7:0]      mem_q [MEM_SIZE];

    assign len_ok    = (ld_len != 16'd0) && (32'(ld_len) <= MEM_SIZE) && (ld_len[1:0] == 2'b00);
    assign wr_en     = (state_q == LOAD) && ld_valid;
    assign last_byte = (addr_q + 16'd1) == len_q;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        len_d   = len_q;
        hold_d  = hold_q;
        err_d   = err_q;
        case (state_q)
            IDLE, RUN: begin
                if (ld_start) begin
                    if (len_ok) begin
                        err_d   = 1'b0;
                        len_d   = ld_len;
                        addr_d  = 16'd0;
                        state_d = LOAD;
                    end else begin
                        err_d   = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            LOAD: begin
                if (ld_valid) begin
                    addr_d = addr_q + 16'd1;
                    if (last_byte) begin
                        hold_d  = '0;
                        state_d = (HOLD_CYCLES == 0) ? RUN : HOLD;
                    end
                end
            end
            HOLD: begin
                // hold_q counts completed HOLD cycles; leave on the last one
                if (32'(hold_q) == HOLD_CYCLES - 1) begin
                    state_d = RUN;
                end else begin
                    hold_d = hold_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            addr_q  <= 16'd0;
            len_q   <= 16'd0;
            hold_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            len_q   <= len_d;
            hold_q  <= hold_d;
            err_q   <= err_d;
        end
    end

    // Storage survives reset so a CPU restart keeps its program image.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[addr_q[AW-1:0]] <= ld_data;
        end
    end

    assign ld_ready  = (state_q == LOAD);
    assign cpu_reset = (state_q != RUN);
    assign load_done = (state_q == RUN);
    assign load_err  = err_q;

    logic [32:0]   pc_end;
    logic [AW-1:0] rd_base;

    assign pc_end  = {1'b0, PC} + 33'd3;
    assign rd_base = PC[AW-1:0];

    always_comb begin
        Instruction = 32'd0;
        if (pc_end < 33'(MEM_SIZE)) begin
            Instruction = {mem_q[rd_base],
                           mem_q[rd_base + AW'(1)],
                           mem_q[rd_base + AW'(2)],
                           mem_q[rd_base + AW'(3)]};
        end
    end

endmodule

// File: doc/inst_mem_loader.md
INST_MEM_LOADER -- requirements
Module: inst_mem_loader

Interface
REQ-001: Parameter MEM_SIZE, default 32'd512, SHALL set the instruction memory size in bytes.
REQ-002: Parameter HOLD_CYCLES, default 2, SHALL set the number of cycles cpu_reset stays asserted after the last byte is loaded.
REQ-003: clk  in  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004: reset  in  1  SHALL be an asynchronous, active-low reset (low = reset).
REQ-005: ld_start  in  1  SHALL be a one-cycle request to begin a program load.
REQ-006: ld_len  in  16  SHALL give the number of bytes to load, sampled with ld_start.
REQ-007: ld_valid  in  1  SHALL flag a valid byte on ld_data.
REQ-008: ld_data  in  8  SHALL carry program bytes, lowest address first.
REQ-009: ld_ready  out  1  SHALL flag that the block accepts a byte this cycle.
REQ-010: PC  in  32  SHALL be the byte fetch address from the CPU.
REQ-011: Instruction  out  32  SHALL be the fetched instruction word.
REQ-012: cpu_reset  out  1  SHALL be an active-high reset driven to the CPU.
REQ-013: load_done  out  1  SHALL flag that a complete program is loaded and the CPU runs.
REQ-014: load_err  out  1  SHALL flag that the last ld_start carried an illegal ld_len.

Function
REQ-015: Storage SHALL be MEM_SIZE bytes; bytes are written only by the loader.
REQ-016: Instruction SHALL be combinational and big-endian: {mem[PC], mem[PC+1], mem[PC+2], mem[PC+3]}.
REQ-017: When PC+3 >= MEM_SIZE, Instruction SHALL be 32'd0 (nop).
REQ-018: FSM states SHALL be IDLE, LOAD, HOLD and RUN.
REQ-019: IDLE: cpu_reset=1, ld_ready=0, load_done=0.
REQ-020: In IDLE or RUN, ld_start with ld_len of 0, greater than MEM_SIZE, or not a multiple of 4 SHALL set load_err=1 and go to or stay in IDLE.
REQ-021: In IDLE or RUN, ld_start with a legal ld_len SHALL clear load_err, latch ld_len, set the write address to 0 and enter LOAD on the next edge.
REQ-022: Entering LOAD from RUN SHALL assert cpu_reset and clear load_done in the first LOAD cycle.
REQ-023: LOAD: ld_ready=1, cpu_reset=1; each edge with ld_valid&ld_ready SHALL write ld_data to mem[addr] and increment addr.
REQ-024: ld_start SHALL be ignored in LOAD and HOLD.
REQ-025: On acceptance of byte number ld_len, the FSM SHALL enter HOLD; ld_ready SHALL be 0 from the next cycle.
REQ-026: HOLD SHALL last exactly HOLD_CYCLES cycles with cpu_reset=1, then enter RUN.
REQ-027: RUN: cpu_reset=0, load_done=1, ld_ready=0; the FSM SHALL stay in RUN until reset or ld_start.
REQ-028: ld_valid deasserted mid-load SHALL stall without timeout; the address SHALL hold.
REQ-029: Bytes beyond the loaded length SHALL keep their prior contents; the block SHALL NOT clear them.

Reset
REQ-030: reset low SHALL immediately force state IDLE, addr 0, cpu_reset=1, ld_ready=0, load_done=0, load_err=0.
REQ-031: Reset SHALL NOT clear memory contents.
REQ-032: Reset during LOAD SHALL abort the load; a fresh ld_start SHALL be required.

Verification
REQ-033: ld_len=8, bytes 00 00 08 20 8C 02 00 00, then PC=0 and PC=4 -> Instruction=32'h00000820 and 32'h8C020000; cpu_reset falls 2 cycles after the 8th byte is accepted; load_done=1.
REQ-034: ld_len=6, and separately ld_len=0 and ld_len=516 -> load_err=1, state IDLE, ld_ready stays 0, cpu_reset=1.
REQ-035: ld_len=4 with ld_valid low for 5 cycles between bytes 2 and 3 -> address holds; the word is written correctly; completion is delayed by 5 cycles.
REQ-036: In RUN, ld_start with ld_len=4 -> cpu_reset=1 and load_done=0 on the next cycle; the new word is at PC=0; the old bytes at PC=4 are unchanged.
REQ-037: reset pulsed low after 3 of 8 bytes -> outputs take reset values asynchronously; a later load of 4 bytes completes normally.
REQ-038: PC=508 and PC=510 with MEM_SIZE=512 -> Instruction equals the bytes at 508..511 for PC=508, and 0 for PC=510.
